// File: rtl/mem_port_arbiter.sv
// Purpose : shares one synchronous memory port between instruction fetch and the load/store path.
// Latency : req seen in IDLE -> mem_req next cycle -> ack the cycle after mem_ready; decode errors ack one cycle after req.
// Backpressure: requesters hold req until their one-cycle ack; the memory stalls by withholding mem_ready.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_rdata/i_err          fetch side (word aligned)
//   d_req/d_we/d_rw_type/d_addr/d_wdata -> d_ack/d_rdata/d_err   load/store side, d_rw_type = {u,w,h,b}
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata, mem_ready/mem_rdata   memory port
//
// Optional feature: define MEM_TIMEOUT_EN to abort a BUS phase after TIMEOUT_CYC cycles
// without mem_ready (the transaction then completes with err=1, rdata=0).
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_rw_type,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;

  // Attributes of the transaction in flight, needed to shape the read data.
  logic       own_d;
  logic       own_we;
  logic [3:0] own_type;
  logic [1:0] own_lo;

  logic        grant_d, grant_i;
  logic        d_bad, i_bad;
  logic [3:0]  d_strb;
  logic [31:0] d_wlane;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  // Arbitration and request decode, evaluated against the live request inputs in IDLE.
  always_comb begin
    grant_d = d_req && !(i_req && (starve_cnt == STARVE_LIM));
    grant_i = i_req && !grant_d;

    d_bad = ($countones(d_rw_type[2:0]) != 1) ||
            (d_rw_type[3] && (d_we || d_rw_type[2])) ||
            (d_rw_type[1] && d_addr[0]) ||
            (d_rw_type[2] && (d_addr[1:0] != 2'b00));
    i_bad = (i_addr[1:0] != 2'b00);

    d_strb  = 4'b1111;
    d_wlane = d_wdata;
    if (d_rw_type[0]) begin
      d_strb  = 4'b0001 << d_addr[1:0];
      d_wlane = {4{d_wdata[7:0]}};
    end else if (d_rw_type[1]) begin
      d_strb  = 4'b0011 << {d_addr[1], 1'b0};
      d_wlane = {2{d_wdata[15:0]}};
    end
    if (!d_we) begin
      d_strb  = 4'b0000;
      d_wlane = 32'd0;
    end
  end

  // Load extraction from the returned word using the latched byte offset and type.
  always_comb begin
    ld_b    = mem_rdata[{own_lo, 3'b000} +: 8];
    ld_h    = own_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    if (own_type[0])
      ld_data = own_type[3] ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
    else if (own_type[1])
      ld_data = own_type[3] ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
    if (own_we)
      ld_data = 32'd0;
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      own_d      <= 1'b0;
      own_we     <= 1'b0;
      own_type   <= 4'd0;
      own_lo     <= 2'd0;
      i_ack      <= 1'b0;
      i_rdata    <= 32'd0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= 32'd0;
      d_err      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt    <= 8'd0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MEM_TIMEOUT_EN
          tmo_cnt <= 8'd0;
`endif
          if (!i_req)
            starve_cnt <= 4'd0;
          if (grant_d) begin
            // A data grant with fetch waiting implies starve_cnt < STARVE_MAX,
            // so the increment saturates naturally at the limit.
            if (i_req)
              starve_cnt <= starve_cnt + 4'd1;
            own_d    <= 1'b1;
            own_we   <= d_we;
            own_type <= d_rw_type;
            own_lo   <= d_addr[1:0];
            if (d_bad) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= 32'd0;
              state   <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[31:2], 2'b00};
              mem_wstrb <= d_strb;
              mem_wdata <= d_wlane;
              state     <= BUS;
            end
          end else if (grant_i) begin
            starve_cnt <= 4'd0;
            own_d      <= 1'b0;
            own_we     <= 1'b0;
            if (i_bad) begin
              i_ack   <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= 32'd0;
              state   <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {i_addr[31:2], 2'b00};
              mem_wstrb <= 4'd0;
              mem_wdata <= 32'd0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (own_d) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= ld_data;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= mem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (own_d) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= 32'd0;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= 32'd0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          // Ack is high for exactly this cycle; response fields return to zero afterwards.
          i_err   <= 1'b0;
          d_err   <= 1'b0;
          i_rdata <= 32'd0;
          d_rdata <= 32'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, random
// transactions against a reference model, starvation, reset-in-BUS and timeout sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_rw_type;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_MAX(4)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC(10)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_rw_type(d_rw_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [3:0]  rwt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          exp_err;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input bit f, input bit we, input logic [3:0] rwt,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int dly, input bit err,
                              input logic [3:0] strb, input logic [31:0] ewd,
                              input logic [31:0] erd);
    vec_t v;
    v.is_fetch = f; v.we = we; v.rwt = rwt; v.addr = addr; v.wdata = wd;
    v.rdata = rd; v.delay = dly; v.exp_err = err; v.exp_strb = strb;
    v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  // Reference model: access size in bytes, alignment by modulo, lanes by replication.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          sz;
    int          off;
    bit          u;
    logic [31:0] mask;
    logic [31:0] val;
    r = v;
    r.exp_strb = 4'd0; r.exp_wdata = 32'd0; r.exp_rdata = 32'd0;
    if (v.is_fetch) begin
      r.exp_err = (v.addr % 4) != 0;
      if (!r.exp_err) r.exp_rdata = v.rdata;
      return r;
    end
    u = v.rwt[3];
    case (v.rwt[2:0])
      3'b001:  sz = 1;
      3'b010:  sz = 2;
      3'b100:  sz = 4;
      default: sz = 0;
    endcase
    r.exp_err = (sz == 0) || (u && (v.we || sz == 4)) || (sz != 0 && (v.addr % sz) != 0);
    if (r.exp_err) return r;
    off = int'(v.addr % 4);
    if (v.we) begin
      r.exp_strb = 4'(((1 << sz) - 1) << off);
      for (int k = 0; k < 4; k++)
        r.exp_wdata[k*8 +: 8] = v.wdata[(k % sz)*8 +: 8];
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      val  = (v.rdata >> (8*off)) & mask;
      if (!u && sz < 4 && ((val >> (8*sz - 1)) & 32'd1) == 32'd1)
        val = val | ~mask;
      r.exp_rdata = val;
    end
    return r;
  endfunction

  // Drive one request, act as memory with the given ready delay, check bus and response.
  task automatic run_txn(input string tag, input vec_t v);
    int cyc  = 0;
    int w    = 0;
    bit done = 0;
    bit seen = 0;
    @(negedge clk);
    if (v.is_fetch) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_rw_type = v.rwt; d_addr = v.addr; d_wdata = v.wdata;
    end
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        if (!seen) begin
          seen = 1;
          chk({tag, " mem_we"},    32'(mem_we),    32'(v.we && !v.is_fetch));
          chk({tag, " mem_addr"},  mem_addr,       v.addr & 32'hFFFF_FFFC);
          chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
          chk({tag, " mem_wdata"}, mem_wdata,      v.exp_wdata);
        end
        if (w >= v.delay) begin
          mem_ready = 1'b1; mem_rdata = v.rdata;
        end else begin
          w++; mem_ready = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (i_ack || d_ack) begin
        done = 1;
        chk({tag, " ack_owner"}, 32'({i_ack, d_ack}), v.is_fetch ? 32'd2 : 32'd1);
        chk({tag, " err"},   32'(v.is_fetch ? i_err : d_err), 32'(v.exp_err));
        chk({tag, " rdata"}, v.is_fetch ? i_rdata : d_rdata,  v.exp_rdata);
        chk({tag, " latency"}, 32'(cyc), v.exp_err ? 32'd1 : 32'(2 + v.delay));
        chk({tag, " bus_used"}, 32'(seen), 32'(!v.exp_err));
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    chk({tag, " acked"}, 32'(done), 32'd1);
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
  endtask

  vec_t tbl[17];

  initial begin
    vec_t v;
    int   n;
    int   cyc;
    int   mcnt;
    bit   exp_f;
    int   bad;

    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_rw_type = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;

    //          f  we rwt      addr        wdata         rdata         dly err strb     exp_wdata     exp_rdata
    tbl[0]  = mk(0, 0, 4'b0001, 32'h103,   32'h0,        32'h80FF_FF00, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80);
    tbl[1]  = mk(0, 1, 4'b0010, 32'h202,   32'h0000_ABCD,32'h0,         1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    tbl[2]  = mk(0, 0, 4'b0100, 32'h005,   32'h0,        32'h1234_5678, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[3]  = mk(0, 0, 4'b1001, 32'h101,   32'h0,        32'h1234_8756, 0, 0, 4'b0000, 32'h0,        32'h0000_0087);
    tbl[4]  = mk(0, 0, 4'b1010, 32'h102,   32'h0,        32'hF00D_1234, 2, 0, 4'b0000, 32'h0,        32'h0000_F00D);
    tbl[5]  = mk(0, 0, 4'b0010, 32'h100,   32'h0,        32'h0000_8001, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8001);
    tbl[6]  = mk(0, 1, 4'b0001, 32'h007,   32'h1234_56A5,32'h0,         0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    tbl[7]  = mk(0, 1, 4'b0100, 32'h010,   32'hDEAD_BEEF,32'h0,         0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    tbl[8]  = mk(0, 0, 4'b0100, 32'h020,   32'h0,        32'hCAFE_F00D, 3, 0, 4'b0000, 32'h0,        32'hCAFE_F00D);
    tbl[9]  = mk(0, 1, 4'b1001, 32'h030,   32'h55,       32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[10] = mk(0, 0, 4'b1100, 32'h030,   32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[11] = mk(0, 0, 4'b0110, 32'h030,   32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[12] = mk(0, 0, 4'b0000, 32'h030,   32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[13] = mk(0, 0, 4'b0010, 32'h003,   32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[14] = mk(1, 0, 4'b0000, 32'h400,   32'h0,        32'h0000_0013, 1, 0, 4'b0000, 32'h0,        32'h0000_0013);
    tbl[15] = mk(1, 0, 4'b0000, 32'h402,   32'h0,        32'h0000_0013, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[16] = mk(0, 0, 4'b0001, 32'h102,   32'h0,        32'h007F_0000, 0, 0, 4'b0000, 32'h0,        32'h0000_007F);

    repeat (3) @(negedge clk);
    chk("reset mem_req",   32'(mem_req),   32'd0);
    chk("reset mem_we",    32'(mem_we),    32'd0);
    chk("reset mem_addr",  mem_addr,       32'd0);
    chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset mem_wdata", mem_wdata,      32'd0);
    chk("reset acks",      32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    chk("reset rdata",     i_rdata | d_rdata, 32'd0);
    rst = 1'b0;

    foreach (tbl[k]) run_txn($sformatf("vec%0d", k), tbl[k]);

    // Fetch and data both held with an always-ready memory: D,D,D,D,F,D...
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_rw_type = 4'b0100; d_addr = 32'h2000;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    n = 0; cyc = 0; mcnt = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        exp_f = (mcnt == 4);
        if (exp_f) mcnt = 0; else mcnt++;
        chk($sformatf("starve grant%0d", n), mem_addr, exp_f ? 32'h1000 : 32'h2000);
        n++;
      end
    end
    chk("starve grants seen", 32'(n), 32'd6);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;

    // Reset while a load sits in BUS: abandoned without ack, retried cleanly.
    v = mk(0, 0, 4'b0100, 32'h40, 32'h0, 32'h1122_3344, 0, 0, 4'b0000, 32'h0, 32'h1122_3344);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_rw_type = 4'b0100; d_addr = 32'h40;
    @(negedge clk);
    chk("rstbus mem_req before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstbus mem_req after", 32'(mem_req), 32'd0);
    chk("rstbus acks after",    32'({i_ack, d_ack}), 32'd0);
    rst = 1'b0; d_req = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack || i_ack || mem_req) bad++;
    end
    chk("rstbus no stray activity", 32'(bad), 32'd0);
    run_txn("rstbus retry", v);

`ifdef MEM_TIMEOUT_EN
    // Fetch against a memory that never answers.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80; mem_ready = 1'b0;
    n = 0; cyc = 0; exp_f = 0;
    while (!exp_f && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) n++;
      if (i_ack) begin
        exp_f = 1;
        chk("tmo i_err",   32'(i_err), 32'd1);
        chk("tmo i_rdata", i_rdata,    32'd0);
        i_req = 1'b0;
      end
    end
    chk("tmo acked",      32'(exp_f), 32'd1);
    chk("tmo bus cycles", 32'(n),     32'd10);
    i_req = 1'b0;
`endif

    // Random traffic checked against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic [3:0] good[5];
      good[0] = 4'b0001; good[1] = 4'b0010; good[2] = 4'b0100;
      good[3] = 4'b1001; good[4] = 4'b1010;
      v.is_fetch = ($urandom % 4) == 0;
      v.we       = $urandom % 2;
      v.rwt      = ($urandom % 4 != 0) ? good[$urandom % 5] : 4'($urandom);
      v.addr     = $urandom;
      if ($urandom % 2 == 1) v.addr[1:0] = 2'b00;
      v.wdata    = $urandom;
      v.rdata    = $urandom;
      v.delay    = $urandom_range(0, 3);
      if (v.is_fetch) v.we = 1'b0;
      v = model(v);
      run_txn($sformatf("rand%0d", t), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
